// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
//   Shared definitions for the UART transmit arbiter slice: default sizes,
//   the arbiter FSM state encoding and a small index-width helper.
//   No ports (package).
package uart_tx_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DW_DEF     = 8;
  localparam int ACK_TO_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  // Width needed to hold an index 0..n-1 (never less than one bit)
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if
//   Bundles the requester handshake, the uart_ctl transmit port and the
//   arbiter status outputs.
//   master : arbiter side (drives req_ready, tx_en, din, gnt_id, busy, ack_to)
//   slave  : requesters + transmitter side (drives req_valid/data/last, tx_rdy)
interface uart_tx_arb_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
);

  localparam int GW = idxWidth(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               tx_rdy;
  logic               tx_en;
  logic [DW-1:0]      din;
  logic [GW-1:0]      gnt_id;
  logic               busy;
  logic               ack_to;

  modport master (
    input  req_valid, req_data, req_last, tx_rdy,
    output req_ready, tx_en, din, gnt_id, busy, ack_to
  );

  modport slave (
    output req_valid, req_data, req_last, tx_rdy,
    input  req_ready, tx_en, din, gnt_id, busy, ack_to
  );

endinterface

// File: rtl/uart_tx_arb_rr_arb.sv
// uart_tx_arb_rr_arb
//   Combinational round-robin picker: returns the first requesting index
//   strictly after the pointer, wrapping modulo NREQ.
//   req_i     : request vector
//   ptr_i     : index that was served last (lowest priority now)
//   gnt_oh_o  : one-hot of the winner
//   gnt_idx_o : binary index of the winner
//   any_o     : at least one request present
module uart_tx_arb_rr_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int GW   = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [GW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [GW-1:0]   gnt_idx_o,
  output logic            any_o
);

  // Scan NREQ positions starting one past the pointer; the first hit wins.
  // The pointer itself is visited last, so a lone requester still re-wins.
  always_comb begin
    int  idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_oh_o[idx]  = 1'b1;
        gnt_idx_o      = GW'(idx);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Shares one byte-wide uart_ctl transmit port among NREQ producers with
//   round-robin arbitration and packet lock (grant held until a byte tagged
//   last has been transmitted). Each byte is sequenced as a one-cycle tx_en
//   pulse, then tx_rdy low, then tx_rdy high; if tx_rdy never falls within
//   ACK_TO cycles the arbiter pulses ack_to and moves on.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_tx_arb_if master modport (requesters, uart_ctl, status)
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DW     = DW_DEF,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.master bus
);

  localparam int GW = idxWidth(NREQ);
  localparam int CW = $clog2(ACK_TO + 1);

  state_e          state_q;
  logic [GW-1:0]   gntId_q;
  logic [NREQ-1:0] gntOh_q;
  logic [GW-1:0]   rrPtr_q;
  logic [DW-1:0]   din_q;
  logic            last_q;
  logic            txEn_q;
  logic            ackTo_q;
  logic [CW-1:0]   ackCnt_q;

  logic [NREQ-1:0] pickOh;
  logic [GW-1:0]   pickIdx;
  logic            pickAny;

  logic            selValid;
  logic [DW-1:0]   selData;
  logic            selLast;

  uart_tx_arb_rr_arb #(.NREQ(NREQ), .GW(GW)) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (rrPtr_q),
    .gnt_oh_o  (pickOh),
    .gnt_idx_o (pickIdx),
    .any_o     (pickAny)
  );

  // Only the locked grantee's lane is looked at; everybody else is ignored
  assign selValid = |(bus.req_valid & gntOh_q);
  assign selData  = bus.req_data[gntId_q*DW +: DW];
  assign selLast  = bus.req_last[gntId_q];

  // Ready is offered to the grantee only while the transmitter is idle, so a
  // byte can never be taken while uart_ctl is still shifting the previous one
  assign bus.req_ready = (state_q == ST_SEND) ? (gntOh_q & {NREQ{bus.tx_rdy}}) : '0;

  assign bus.tx_en  = txEn_q;
  assign bus.din    = din_q;
  assign bus.gnt_id = gntId_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.ack_to = ackTo_q;

  // Arbiter FSM. tx_en and ack_to are single-cycle pulses, cleared by default
  // every cycle. The tx_en cycle is already the first WAIT_ACK cycle, so the
  // timeout fires ACK_TO cycles after tx_en. The round-robin pointer moves
  // only when a packet is released, which gives the packet lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gntId_q  <= '0;
      gntOh_q  <= '0;
      rrPtr_q  <= GW'(NREQ - 1);
      din_q    <= '0;
      last_q   <= 1'b0;
      txEn_q   <= 1'b0;
      ackTo_q  <= 1'b0;
      ackCnt_q <= '0;
    end else begin
      txEn_q  <= 1'b0;
      ackTo_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pickAny) begin
            gntId_q <= pickIdx;
            gntOh_q <= pickOh;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (selValid && bus.tx_rdy) begin
            din_q    <= selData;
            last_q   <= selLast;
            txEn_q   <= 1'b1;
            ackCnt_q <= '0;
            state_q  <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!bus.tx_rdy) begin
            state_q <= ST_WAIT_DONE;
          end else if (ackCnt_q == CW'(ACK_TO - 1)) begin
            ackTo_q <= 1'b1;
            state_q <= ST_WAIT_DONE;
          end else begin
            ackCnt_q <= ackCnt_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_rdy) begin
            if (last_q) begin
              rrPtr_q <= gntId_q;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_SEND;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
//   Directed bench for uart_tx_arb: a table of arbitration vectors plus
//   hand-written sequences for packet lock, timeout and reset corner cases.
//   A small uart_ctl model holds tx_rdy low for UART_BUSY cycles after tx_en.
module tb_uart_tx_arb;
  import uart_tx_arb_pkg::*;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int ACK_TO    = 16;
  localparam int UART_BUSY = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .DW(DW), .ACK_TO(ACK_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vecCount  = 0;
  int missCount = 0;

  // Transmitter model: busy for UART_BUSY cycles after it sees tx_en,
  // unless stuckMode makes it ignore tx_en entirely. Unaffected by rst.
  int uartCnt   = 0;
  bit stuckMode = 1'b0;

  always @(posedge clk) begin
    if (bus.tx_en === 1'b1 && !stuckMode) uartCnt <= UART_BUSY;
    else if (uartCnt > 0)                 uartCnt <= uartCnt - 1;
  end

  assign bus.tx_rdy = (uartCnt == 0);

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] din;
  } txRec_t;

  txRec_t txLog[$];

  typedef struct {
    logic [3:0] validMask;
    logic [1:0] expGnt;
    logic [7:0] expDin;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Log every transmitted byte; the transmitter must be idle when one starts
  always @(negedge clk) begin
    if (bus.tx_en === 1'b1) begin
      txLog.push_back('{bus.gnt_id, bus.din});
      checkOutput("txRdyAtTxEn", 32'(bus.tx_rdy), 32'd1);
    end
  end

  task automatic applyStimulus(input logic [3:0] validMask, input logic [3:0] lastMask);
    bus.req_valid = validMask;
    bus.req_last  = lastMask;
  endtask

  task automatic setReq(input int i, input bit v, input logic [7:0] d, input bit l);
    bus.req_valid[i]      = v;
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]       = l;
  endtask

  task automatic waitTxEn(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("idleReached", 32'(bus.busy), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends even if a bounded wait is missed
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic [3:0] readyMask;
    logic [1:0] expG[4];
    logic [7:0] expD[4];

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst tx_en",     32'(bus.tx_en),     32'd0);
    checkOutput("rst din",       32'(bus.din),       32'd0);
    checkOutput("rst req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst gnt_id",    32'(bus.gnt_id),    32'd0);
    checkOutput("rst busy",      32'(bus.busy),      32'd0);
    checkOutput("rst ack_to",    32'(bus.ack_to),    32'd0);
    rst = 1'b0;

    // Single byte from requester 0: one tx_en, 12 busy cycles after tx_en
    // (1 tx_en cycle, 1 cycle to see tx_rdy fall, 10 busy-low cycles)
    $display("[TB] single byte from requester 0");
    txLog.delete();
    setReq(0, 1'b1, 8'h41, 1'b1);
    waitTxEn(ok, n);
    checkOutput("t1 txEnSeen", 32'(ok), 32'd1);
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitIdle(n);
    checkOutput("t1 busyCycles", 32'(n), 32'd12);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t1 txCount", 32'(txLog.size()), 32'd1);
    checkOutput("t1 din",     32'(bus.din),       32'h41);
    checkOutput("t1 gnt_id",  32'(bus.gnt_id),    32'd0);

    // Table: single-byte packets, pointer carried from row to row
    $display("[TB] round-robin vector table");
    doReset();
    vecs[0]  = '{4'b1111, 2'd0, 8'hA0};
    vecs[1]  = '{4'b1111, 2'd1, 8'hA1};
    vecs[2]  = '{4'b1111, 2'd2, 8'hA2};
    vecs[3]  = '{4'b1111, 2'd3, 8'hA3};
    vecs[4]  = '{4'b1111, 2'd0, 8'hA0};
    vecs[5]  = '{4'b0100, 2'd2, 8'hA2};
    vecs[6]  = '{4'b1001, 2'd3, 8'hA3};
    vecs[7]  = '{4'b0011, 2'd0, 8'hA0};
    vecs[8]  = '{4'b0110, 2'd1, 8'hA1};
    vecs[9]  = '{4'b0001, 2'd0, 8'hA0};
    vecs[10] = '{4'b1000, 2'd3, 8'hA3};
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k].validMask, 4'hF);
      readyMask = '0;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        if (bus.req_ready !== 4'b0000) readyMask = bus.req_ready;
        if (bus.tx_en === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      checkOutput($sformatf("vec%0d txEnSeen", k), 32'(ok), 32'd1);
      checkOutput($sformatf("vec%0d gnt_id", k), 32'(bus.gnt_id), 32'(vecs[k].expGnt));
      checkOutput($sformatf("vec%0d din", k), 32'(bus.din), 32'(vecs[k].expDin));
      checkOutput($sformatf("vec%0d req_ready", k), 32'(readyMask), 32'd1 << vecs[k].expGnt);
      waitIdle(n);
    end
    applyStimulus(4'b0000, 4'b0000);

    // Three-byte packet from requester 1 while requester 2 waits
    $display("[TB] packet lock with competing requester");
    txLog.delete();
    setReq(1, 1'b1, 8'h10, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t3 byte0 seen", 32'(ok), 32'd1);
    setReq(2, 1'b1, 8'h22, 1'b1);
    setReq(1, 1'b1, 8'h11, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t3 byte1 seen", 32'(ok), 32'd1);
    setReq(1, 1'b1, 8'h12, 1'b1);
    waitTxEn(ok, n);
    checkOutput("t3 byte2 seen", 32'(ok), 32'd1);
    setReq(1, 1'b0, 8'h00, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t3 req2 seen", 32'(ok), 32'd1);
    setReq(2, 1'b0, 8'h00, 1'b0);
    waitIdle(n);
    expG = '{2'd1, 2'd1, 2'd1, 2'd2};
    expD = '{8'h10, 8'h11, 8'h12, 8'h22};
    checkOutput("t3 txCount", 32'(txLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < txLog.size(); i++) begin
      checkOutput($sformatf("t3 log%0d gnt", i), 32'(txLog[i].gnt), 32'(expG[i]));
      checkOutput($sformatf("t3 log%0d din", i), 32'(txLog[i].din), 32'(expD[i]));
    end

    // Grantee goes quiet mid-packet: lock held, nothing sent for requester 3
    $display("[TB] grantee stalls mid-packet");
    txLog.delete();
    setReq(1, 1'b1, 8'h61, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t6 byte0 seen", 32'(ok), 32'd1);
    setReq(1, 1'b0, 8'h00, 1'b0);
    setReq(3, 1'b1, 8'h63, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    checkOutput("t6 stall txCount", 32'(txLog.size()), 32'd1);
    checkOutput("t6 stall gnt_id",  32'(bus.gnt_id),    32'd1);
    checkOutput("t6 stall busy",    32'(bus.busy),      32'd1);
    setReq(1, 1'b1, 8'h62, 1'b1);
    waitTxEn(ok, n);
    checkOutput("t6 resume seen", 32'(ok), 32'd1);
    checkOutput("t6 resume gnt",  32'(bus.gnt_id), 32'd1);
    checkOutput("t6 resume din",  32'(bus.din),    32'h62);
    setReq(1, 1'b0, 8'h00, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t6 req3 seen", 32'(ok), 32'd1);
    checkOutput("t6 req3 gnt",  32'(bus.gnt_id), 32'd3);
    checkOutput("t6 req3 din",  32'(bus.din),    32'h63);
    setReq(3, 1'b0, 8'h00, 1'b0);
    waitIdle(n);

    // Transmitter never acknowledges: ack_to pulses ACK_TO cycles after tx_en
    $display("[TB] acknowledge timeout");
    stuckMode = 1'b1;
    setReq(0, 1'b1, 8'h44, 1'b1);
    waitTxEn(ok, n);
    checkOutput("t4 txEnSeen", 32'(ok), 32'd1);
    setReq(0, 1'b0, 8'h00, 1'b0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack_to === 1'b1) break;
    end
    checkOutput("t4 ackToDelay", 32'(n), 32'(ACK_TO));
    @(posedge clk);
    #1;
    checkOutput("t4 ackToWidth", 32'(bus.ack_to), 32'd0);
    waitIdle(n);
    stuckMode = 1'b0;

    // Reset while waiting for the transmitter mid-packet
    $display("[TB] reset during WAIT_DONE");
    setReq(2, 1'b1, 8'h52, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t5 txEnSeen", 32'(ok), 32'd1);
    checkOutput("t5 gnt_id",   32'(bus.gnt_id), 32'd2);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5 uartBusy", 32'(bus.tx_rdy), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 rst tx_en",     32'(bus.tx_en),     32'd0);
    checkOutput("t5 rst din",       32'(bus.din),       32'd0);
    checkOutput("t5 rst req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("t5 rst gnt_id",    32'(bus.gnt_id),    32'd0);
    checkOutput("t5 rst busy",      32'(bus.busy),      32'd0);
    checkOutput("t5 rst ack_to",    32'(bus.ack_to),    32'd0);
    setReq(0, 1'b1, 8'h50, 1'b1);
    setReq(2, 1'b1, 8'h53, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitTxEn(ok, n);
    checkOutput("t5 first seen", 32'(ok), 32'd1);
    checkOutput("t5 first gnt",  32'(bus.gnt_id), 32'd0);
    checkOutput("t5 first din",  32'(bus.din),    32'h50);
    setReq(0, 1'b0, 8'h00, 1'b0);
    waitTxEn(ok, n);
    checkOutput("t5 second seen", 32'(ok), 32'd1);
    checkOutput("t5 second gnt",  32'(bus.gnt_id), 32'd2);
    checkOutput("t5 second din",  32'(bus.din),    32'h53);
    setReq(2, 1'b0, 8'h00, 1'b0);
    waitIdle(n);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
